hazard_tnew_pipe: RTL and testbench

//  Hazard-tracking shadow pipeline for the 5-stage MIPS core.

---
 rtl/hazard_tnew_if.sv | 33 +++
 rtl/hazard_tnew_pipe.sv | 69 ++++++
 tb/tb_hazard_tnew_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/hazard_tnew_if.sv
// Stall-unit-facing bundle of the hazard shadow pipeline: D-side inputs and per-stage state.
interface hazard_tnew_if #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic [ADDR_W-1:0] D_RFDst;
  logic [TNEW_W-1:0] D_Tnew;
  logic [ADDR_W-1:0] E_RFDst;
  logic [TNEW_W-1:0] Tnew_E;
  logic [ADDR_W-1:0] M_RFDst;
  logic [TNEW_W-1:0] Tnew_M;
  logic [ADDR_W-1:0] W_RFDst;
  logic              E_fwd_ok;
  logic              M_fwd_ok;
  logic              W_fwd_ok;
  logic [CNT_W-1:0]  bubble_cnt;

  // Driver side: decode stage and stall unit.
  modport master (
    output stall, D_RFDst, D_Tnew,
    input  E_RFDst, Tnew_E, M_RFDst, Tnew_M, W_RFDst,
    input  E_fwd_ok, M_fwd_ok, W_fwd_ok, bubble_cnt
  );

  // Pipeline side.
  modport slave (
    input  stall, D_RFDst, D_Tnew,
    output E_RFDst, Tnew_E, M_RFDst, Tnew_M, W_RFDst,
    output E_fwd_ok, M_fwd_ok, W_fwd_ok, bubble_cnt
  );
endinterface

// File: rtl/hazard_tnew_pipe.sv
// Hazard-tracking shadow pipeline: carries RFDst/Tnew from D through E, M, W,
// turns a stall into an E bubble, and counts bubbles (saturating).
module hazard_tnew_pipe #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,   // synchronous, active low
  hazard_tnew_if.slave        bus
);
  logic [ADDR_W-1:0] e_dst_q, e_dst_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [ADDR_W-1:0] m_dst_q, m_dst_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [ADDR_W-1:0] w_dst_q, w_dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: every stage advances every cycle; a stall only replaces the D->E entry.
  always_comb begin
    e_dst_d  = '0;
    e_tnew_d = '0;
    cnt_d    = cnt_q;
    if (bus.stall) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      e_dst_d  = bus.D_RFDst;
      // $0 is never a hazard, so its Tnew is forced to zero.
      e_tnew_d = (bus.D_RFDst == '0) ? '0 : bus.D_Tnew;
    end
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - 1'b1;
    // Tnew is not carried into W: anything still pending there would be invalid.
    w_dst_d  = m_dst_q;
  end

  // Stage registers; reset beats stall and drops all in-flight entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      w_dst_q  <= '0;
      cnt_q    <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      cnt_q    <= cnt_d;
    end
  end

  // Forward-valid flags decode only registered state, so no loop through the stall unit.
  always_comb begin
    bus.E_fwd_ok = (e_dst_q != '0) && (e_tnew_q == '0);
    bus.M_fwd_ok = (m_dst_q != '0) && (m_tnew_q == '0);
    bus.W_fwd_ok = (w_dst_q != '0);
  end

  assign bus.E_RFDst    = e_dst_q;
  assign bus.Tnew_E     = e_tnew_q;
  assign bus.M_RFDst    = m_dst_q;
  assign bus.Tnew_M     = m_tnew_q;
  assign bus.W_RFDst    = w_dst_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_tnew_pipe.sv
// Directed table-driven bench for hazard_tnew_pipe; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_hazard_tnew_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_tnew_if #(.ADDR_W(5), .TNEW_W(2), .CNT_W(16)) bus ();
  hazard_tnew_if #(.ADDR_W(5), .TNEW_W(2), .CNT_W(2))  bus2 ();

  hazard_tnew_pipe #(.ADDR_W(5), .TNEW_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  hazard_tnew_pipe #(.ADDR_W(5), .TNEW_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    int rst, stall, d_dst, d_tn;
    int e_dst, te, m_dst, tm, w_dst, eok, mok, wok, cnt, cnt2;
  } vec_t;

  vec_t vecs[17];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int rst, input int stall, input int d_dst, input int d_tn);
    @(negedge clk);
    reset         = rst[0];
    bus.stall     = stall[0];
    bus.D_RFDst   = d_dst[4:0];
    bus.D_Tnew    = d_tn[1:0];
    bus2.stall    = stall[0];
    bus2.D_RFDst  = d_dst[4:0];
    bus2.D_Tnew   = d_tn[1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst stl dD dT | eD tE mD tM wD eok mok wok cnt cnt2
    vecs[0]  = '{0, 0, 5, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // held in reset
    vecs[1]  = '{0, 0, 5, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 5, 2,  5, 2, 0, 0, 0, 0, 0, 0, 0, 0};  // mult-class enters E
    vecs[3]  = '{1, 0, 8, 0,  8, 0, 5, 1, 0, 1, 0, 0, 0, 0};  // ALU: E fwd ok at once
    vecs[4]  = '{1, 1, 9, 1,  0, 0, 8, 0, 5, 0, 1, 1, 1, 1};  // stall 1
    vecs[5]  = '{1, 1, 9, 1,  0, 0, 0, 0, 8, 0, 0, 1, 2, 2};  // stall 2
    vecs[6]  = '{1, 1, 9, 1,  0, 0, 0, 0, 0, 0, 0, 0, 3, 3};  // stall 3
    vecs[7]  = '{1, 0, 9, 1,  9, 1, 0, 0, 0, 0, 0, 0, 3, 3};  // held instr enters E
    vecs[8]  = '{1, 0, 0, 2,  0, 0, 9, 0, 0, 0, 1, 0, 3, 3};  // $0: Tnew forced 0
    vecs[9]  = '{1, 0, 3, 3,  3, 3, 0, 0, 9, 0, 0, 1, 3, 3};  // max Tnew
    vecs[10] = '{1, 0, 4, 1,  4, 1, 3, 2, 0, 0, 0, 0, 3, 3};
    vecs[11] = '{1, 0, 0, 0,  0, 0, 4, 0, 3, 0, 1, 1, 3, 3};
    vecs[12] = '{1, 1, 7, 2,  0, 0, 0, 0, 4, 0, 0, 1, 4, 3};  // small counter saturated
    vecs[13] = '{1, 0, 7, 2,  7, 2, 0, 0, 0, 0, 0, 0, 4, 3};
    vecs[14] = '{1, 0, 6, 0,  6, 0, 7, 1, 0, 1, 0, 0, 4, 3};
    vecs[15] = '{0, 1, 2, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // reset beats stall
    vecs[16] = '{1, 0, 2, 1,  2, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    reset = 1'b0;
    bus.stall = 1'b0;  bus.D_RFDst = '0;  bus.D_Tnew = '0;
    bus2.stall = 1'b0; bus2.D_RFDst = '0; bus2.D_Tnew = '0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].d_dst, vecs[i].d_tn);
      check("E_RFDst",    i, int'(bus.E_RFDst),    vecs[i].e_dst);
      check("Tnew_E",     i, int'(bus.Tnew_E),     vecs[i].te);
      check("M_RFDst",    i, int'(bus.M_RFDst),    vecs[i].m_dst);
      check("Tnew_M",     i, int'(bus.Tnew_M),     vecs[i].tm);
      check("W_RFDst",    i, int'(bus.W_RFDst),    vecs[i].w_dst);
      check("E_fwd_ok",   i, int'(bus.E_fwd_ok),   vecs[i].eok);
      check("M_fwd_ok",   i, int'(bus.M_fwd_ok),   vecs[i].mok);
      check("W_fwd_ok",   i, int'(bus.W_fwd_ok),   vecs[i].wok);
      check("bubble_cnt", i, int'(bus.bubble_cnt), vecs[i].cnt);
      check("bubble_cnt_sat", i, int'(bus2.bubble_cnt), vecs[i].cnt2);
    end

    // Five-cycle stall from a fresh count: wide counter climbs 1..5, CNT_W=2 stops at 3.
    drive(0, 0, 0, 0);
    check("cnt_reset", 100, int'(bus.bubble_cnt), 0);
    check("cnt2_reset", 100, int'(bus2.bubble_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 10, 2);
      check("cnt_run", 100 + k, int'(bus.bubble_cnt), k);
      check("cnt2_sat", 100 + k, int'(bus2.bubble_cnt), (k > 3) ? 3 : k);
      check("E_bubble", 100 + k, int'(bus.E_RFDst), 0);
    end
    drive(1, 0, 10, 2);
    check("E_after_stall", 106, int'(bus.E_RFDst), 10);
    check("TE_after_stall", 106, int'(bus.Tnew_E), 2);
    check("cnt_hold", 106, int'(bus.bubble_cnt), 5);
    drive(1, 0, 0, 0);
    check("M_after_stall", 107, int'(bus.M_RFDst), 10);
    check("TM_after_stall", 107, int'(bus.Tnew_M), 1);
    check("M_fwd_pending", 107, int'(bus.M_fwd_ok), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
